// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the KSA controller and, later, the PRGA stage.
//   - ksa_state_t   : one-hot-free encoded KSA sequencer states
//   - S_SIZE        : number of entries in the S permutation
//   - KEY_LENGTH    : secret-key length in bytes
//   - ADDR_W/DATA_W : S-RAM address and data widths
//   - key_byte()    : selects key byte idx, byte 0 being the most-significant
package rc4_pkg;

   localparam int S_SIZE     = 256;
   localparam int KEY_LENGTH = 3;
   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_SI,
      ST_LT_SI,
      ST_RD_SJ,
      ST_LT_SJ,
      ST_WR_SI,
      ST_WR_SJ,
      ST_DONE
   } ksa_state_t;

   // Byte 0 occupies the top of the key vector, so byte idx starts at
   // bit 8*(KEY_LENGTH-1-idx).
   function automatic logic [7:0] key_byte(input logic [8*KEY_LENGTH-1:0] key,
                                           input int idx);
      return key[8*(KEY_LENGTH-1-idx) +: 8];
   endfunction

endpackage

// File: rtl/rc4_j_update.sv
// RC4 j-index update: j_next = j + si + kbyte, wrapping at 2**W.
// Shared by the KSA controller and the PRGA stage.
//   j      in  W  current j
//   si     in  W  S[i] just read
//   kbyte  in  W  key byte (KSA) or zero (PRGA)
//   j_next out W  updated j
module rc4_j_update #(
   parameter int W = 8
) (
   input  logic [W-1:0] j,
   input  logic [W-1:0] si,
   input  logic [W-1:0] kbyte,
   output logic [W-1:0] j_next
);

   assign j_next = j + si + kbyte;

endmodule

// File: rtl/rc4_ksa_controller.sv
// RC4 key-scheduling controller. Walks i = 0..255 over the S array in the
// shared single-port RAM, six cycles per i: read S[i], update j, read S[j],
// write S[j] to i and S[i] to j.
//   clk          in   1             system clock
//   reset_n      in   1             asynchronous active-low reset
//   start        in   1             level request; key latched when accepted
//   secret_key   in   8*KEY_LENGTH  key, byte 0 in the top bits
//   mem_q        in   DATA_W        RAM read data (one cycle after address)
//   mem_address  out  ADDR_W        RAM address
//   mem_data     out  DATA_W        RAM write data (0 when not writing)
//   mem_wren     out  1             RAM write enable
//   busy         out  1             controller owns the RAM port
//   finish       out  1             KSA complete, held until start drops
module rc4_ksa_controller
   import rc4_pkg::*;
#(
   parameter int KEY_LENGTH = rc4_pkg::KEY_LENGTH,
   parameter int ADDR_W     = rc4_pkg::ADDR_W,
   parameter int DATA_W     = rc4_pkg::DATA_W
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    start,
   input  logic [8*KEY_LENGTH-1:0] secret_key,
   input  logic [DATA_W-1:0]       mem_q,
   output logic [ADDR_W-1:0]       mem_address,
   output logic [DATA_W-1:0]       mem_data,
   output logic                    mem_wren,
   output logic                    busy,
   output logic                    finish
);

   localparam int KI_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

   ksa_state_t              state_reg, state_next;
   logic [ADDR_W-1:0]       i_reg, i_next;
   logic [ADDR_W-1:0]       j_reg, j_next;
   logic [DATA_W-1:0]       si_reg, si_next;
   logic [DATA_W-1:0]       sj_reg, sj_next;
   logic [8*KEY_LENGTH-1:0] key_reg, key_next;
   // Tracks i mod KEY_LENGTH incrementally so no divider is needed.
   logic [KI_W-1:0]         kidx_reg, kidx_next;
   logic [ADDR_W-1:0]       j_calc;

   rc4_j_update #(.W(ADDR_W)) u_j_update (
      .j      (j_reg),
      .si     (mem_q),
      .kbyte  (key_byte(key_reg, int'(kidx_reg))),
      .j_next (j_calc)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         i_reg     <= '0;
         j_reg     <= '0;
         si_reg    <= '0;
         sj_reg    <= '0;
         key_reg   <= '0;
         kidx_reg  <= '0;
      end else begin
         state_reg <= state_next;
         i_reg     <= i_next;
         j_reg     <= j_next;
         si_reg    <= si_next;
         sj_reg    <= sj_next;
         key_reg   <= key_next;
         kidx_reg  <= kidx_next;
      end
   end

   // Outputs depend only on registered state, so mem_wren cannot glitch
   // on input activity.
   always_comb begin
      state_next  = state_reg;
      i_next      = i_reg;
      j_next      = j_reg;
      si_next     = si_reg;
      sj_next     = sj_reg;
      key_next    = key_reg;
      kidx_next   = kidx_reg;
      mem_address = '0;
      mem_data    = '0;
      mem_wren    = 1'b0;
      busy        = 1'b1;
      finish      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            busy = 1'b0;
            if (start) begin
               key_next   = secret_key;
               i_next     = '0;
               j_next     = '0;
               kidx_next  = '0;
               state_next = ST_RD_SI;
            end
         end
         ST_RD_SI: begin
            mem_address = i_reg;
            state_next  = ST_LT_SI;
         end
         ST_LT_SI: begin
            si_next    = mem_q;
            j_next     = j_calc;
            state_next = ST_RD_SJ;
         end
         ST_RD_SJ: begin
            mem_address = j_reg;
            state_next  = ST_LT_SJ;
         end
         ST_LT_SJ: begin
            sj_next    = mem_q;
            state_next = ST_WR_SI;
         end
         ST_WR_SI: begin
            mem_address = i_reg;
            mem_data    = sj_reg;
            mem_wren    = 1'b1;
            state_next  = ST_WR_SJ;
         end
         ST_WR_SJ: begin
            mem_address = j_reg;
            mem_data    = si_reg;
            mem_wren    = 1'b1;
            // Stop at the last entry rather than letting i wrap into a
            // second pass.
            if (i_reg == ADDR_W'(S_SIZE - 1)) begin
               state_next = ST_DONE;
            end else begin
               i_next     = i_reg + 1'b1;
               kidx_next  = (kidx_reg == KI_W'(KEY_LENGTH - 1)) ? '0 : kidx_reg + 1'b1;
               state_next = ST_RD_SI;
            end
         end
         ST_DONE: begin
            busy   = 1'b0;
            finish = 1'b1;
            if (!start) state_next = ST_IDLE;
         end
         default: begin
            busy       = 1'b0;
            state_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_rc4_ksa_controller.sv
// Directed bench for rc4_ksa_controller with a behavioural synchronous RAM
// and a software RC4 KSA reference for full-array comparison.
module tb_rc4_ksa_controller;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic [23:0] secret_key;
   logic [7:0]  mem_q;
   logic [7:0]  mem_address;
   logic [7:0]  mem_data;
   logic        mem_wren;
   logic        busy;
   logic        finish;

   logic [7:0]  ram     [256];
   logic [7:0]  model_s [256];

   int n_vec;
   int n_err;

   logic [15:0] wq[$];
   int          busy_cnt;
   int          wr_cnt;
   int          fin_cyc;

   rc4_ksa_controller dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .secret_key  (secret_key),
      .mem_q       (mem_q),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_wren    (mem_wren),
      .busy        (busy),
      .finish      (finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM: registered read, write on the edge ending the cycle.
   always @(posedge clk) begin
      if (mem_wren) ram[mem_address] <= mem_data;
      mem_q <= ram[mem_address];
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic init_ram();
      for (int k = 0; k < 256; k++) ram[k] = 8'(k);
   endtask

   task automatic model_ksa(input logic [23:0] key);
      logic [7:0] j;
      logic [7:0] t;
      logic [7:0] kb;
      int         sh;
      for (int k = 0; k < 256; k++) model_s[k] = 8'(k);
      j = 8'h00;
      for (int k = 0; k < 256; k++) begin
         sh = 8 * (2 - (k % 3));
         kb = 8'(key >> sh);
         j  = j + model_s[k] + kb;
         t  = model_s[k];
         model_s[k] = model_s[j];
         model_s[j] = t;
      end
   endtask

   task automatic compare_ram(input string tag);
      for (int k = 0; k < 256; k++) check_val($sformatf("%s_s%0d", tag, k), 32'(ram[k]), 32'(model_s[k]));
   endtask

   // Call right after a negedge; the next posedge samples start (edge E).
   // Cycle c is the c-th cycle after E, sampled on its negedge.
   task automatic run_ksa(input logic [23:0] key, input int drop_at);
      wq.delete();
      busy_cnt   = 0;
      wr_cnt     = 0;
      fin_cyc    = 0;
      secret_key = key;
      start      = 1'b1;
      for (int c = 1; c <= 2000; c++) begin
         @(negedge clk);
         if (c == drop_at) start = 1'b0;
         if (c == 20) secret_key = ~key;
         if (busy) busy_cnt++;
         if (mem_wren) begin
            wr_cnt++;
            wq.push_back({mem_address, mem_data});
         end
         if (finish) begin
            fin_cyc = c;
            break;
         end
      end
      if (fin_cyc == 0) check_val("finish_timeout", 32'(fin_cyc), 32'd1537);
      $display("run key=%06h finish_cycle=%0d busy=%0d writes=%0d", key, fin_cyc, busy_cnt, wr_cnt);
   endtask

   task automatic check_write(input string tag, input int idx, input logic [15:0] exp);
      logic [15:0] got;
      got = (idx < wq.size()) ? wq[idx] : 16'hxxxx;
      check_val(tag, 32'(got), 32'(exp));
   endtask

   initial begin
      int seen;
      n_vec      = 0;
      n_err      = 0;
      reset_n    = 1'b0;
      start      = 1'b0;
      secret_key = 24'h0;
      init_ram();
      repeat (3) @(negedge clk);
      check_val("rst_busy",   32'(busy),        32'd0);
      check_val("rst_finish", 32'(finish),      32'd0);
      check_val("rst_wren",   32'(mem_wren),    32'd0);
      check_val("rst_addr",   32'(mem_address), 32'd0);
      check_val("rst_data",   32'(mem_data),    32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Key 000000: j goes 0,1,3 over the first three iterations.
      init_ram();
      run_ksa(24'h000000, 0);
      check_val("k0_latency", 32'(fin_cyc),  32'd1537);
      check_val("k0_busy",    32'(busy_cnt), 32'd1536);
      check_val("k0_writes",  32'(wr_cnt),   32'd512);
      check_write("k0_w0", 0, {8'd0, 8'd0});
      check_write("k0_w1", 1, {8'd0, 8'd0});
      check_write("k0_w2", 2, {8'd1, 8'd1});
      check_write("k0_w3", 3, {8'd1, 8'd1});
      check_write("k0_w4", 4, {8'd2, 8'd3});
      check_write("k0_w5", 5, {8'd3, 8'd2});
      model_ksa(24'h000000);
      compare_ram("k0");
      // start still high: stay in DONE, no rerun.
      repeat (5) @(negedge clk);
      check_val("hold_finish", 32'(finish), 32'd1);
      check_val("hold_busy",   32'(busy),   32'd0);
      start = 1'b0;
      @(negedge clk);
      check_val("hold_release", 32'(finish), 32'd0);

      // Key 010203.
      init_ram();
      run_ksa(24'h010203, 0);
      check_write("k123_w0", 0, {8'd0, 8'd1});
      check_write("k123_w1", 1, {8'd1, 8'd0});
      check_write("k123_w2", 2, {8'd1, 8'd3});
      check_write("k123_w3", 3, {8'd3, 8'd0});
      check_val("k123_latency", 32'(fin_cyc), 32'd1537);
      model_ksa(24'h010203);
      compare_ram("k123");
      start = 1'b0;
      @(negedge clk);

      // Key 000249, start dropped at cycle 10, key changed at cycle 20.
      init_ram();
      run_ksa(24'h000249, 10);
      check_val("k249_latency", 32'(fin_cyc), 32'd1537);
      model_ksa(24'h000249);
      compare_ram("k249");
      @(negedge clk);
      check_val("drop_finish_pulse", 32'(finish), 32'd0);
      check_val("drop_idle_busy",    32'(busy),   32'd0);
      repeat (3) @(negedge clk);
      check_val("drop_no_rerun", 32'(busy), 32'd0);

      // Reset in the middle of a run (first WR_SI).
      init_ram();
      secret_key = 24'h010203;
      start      = 1'b1;
      seen       = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (mem_wren) begin
            seen = 1;
            break;
         end
      end
      check_val("mid_reach_wr", 32'(seen), 32'd1);
      reset_n = 1'b0;
      #1;
      check_val("mid_rst_busy",   32'(busy),     32'd0);
      check_val("mid_rst_wren",   32'(mem_wren), 32'd0);
      check_val("mid_rst_finish", 32'(finish),   32'd0);
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_val("post_rst_idle", 32'(busy), 32'd0);
      init_ram();
      run_ksa(24'h010203, 0);
      check_write("rerun_w0", 0, {8'd0, 8'd1});
      check_write("rerun_w1", 1, {8'd1, 8'd0});
      check_val("rerun_latency", 32'(fin_cyc), 32'd1537);
      start = 1'b0;
      @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
